// File: rtl/weight_cache_pingpong_if.sv
// Weight load stream (valid/ready) between the weight loader and weight_cache_pingpong.
// The loader uses the master modport and the cache uses the slave modport.
interface weight_cache_pingpong_if #(
    parameter int unsigned DW = 8
);
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/weight_cache_pingpong.sv
// Double-buffered N x N weight cache: a row-major stream fills the shadow bank while
// fix_b serves the active bank. Optional macro WCACHE_AUTO_SWAP_EN swaps as soon as the shadow bank is full.
module weight_cache_pingpong #(
    parameter int unsigned N  = 3,
    parameter int unsigned DW = 8,
    parameter int unsigned CW = $clog2(N*N+1)
) (
    input  logic                clk,
    input  logic                rst,
    weight_cache_pingpong_if.slave wr,
    input  logic                load_clr,
    input  logic                swap_req,
    input  logic                hold,
    output logic [N*N*DW-1:0]   fix_b,
    output logic                shadow_full,
    output logic                active_valid,
    output logic [CW-1:0]       load_cnt
);
    localparam int unsigned NN = N * N;

    typedef enum logic {StLoad, StFull} state_e;

    state_e                 state_q, state_d;
    logic                   bank_sel_q, bank_sel_d;
    logic                   active_valid_q, active_valid_d;
    logic [CW-1:0]          load_cnt_q, load_cnt_d;
    logic [NN-1:0][DW-1:0]  bank0_q, bank1_q;

    logic wr_fire;
    logic swap_en;
    logic swap_go;

`ifdef WCACHE_AUTO_SWAP_EN
    // swap_req stays on the port but never gates the swap in this build.
    assign swap_en = swap_req | 1'b1;
`else
    assign swap_en = swap_req;
`endif

    assign swap_go = (state_q == StFull) && swap_en && !hold;
    assign wr_fire = (state_q == StLoad) && wr.wr_valid && !load_clr;

    always_comb begin
        state_d        = state_q;
        bank_sel_d     = bank_sel_q;
        active_valid_d = active_valid_q;
        load_cnt_d     = load_cnt_q;
        if (load_clr) begin
            load_cnt_d = '0;
            state_d    = StLoad;
        end else if (swap_go) begin
            bank_sel_d     = ~bank_sel_q;
            active_valid_d = 1'b1;
            load_cnt_d     = '0;
            state_d        = StLoad;
        end else if (wr_fire) begin
            load_cnt_d = load_cnt_q + CW'(1);
            if (load_cnt_q == CW'(NN - 1)) begin
                state_d = StFull;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StLoad;
            bank_sel_q     <= 1'b0;
            active_valid_q <= 1'b0;
            load_cnt_q     <= '0;
            bank0_q        <= '0;
            bank1_q        <= '0;
        end else begin
            state_q        <= state_d;
            bank_sel_q     <= bank_sel_d;
            active_valid_q <= active_valid_d;
            load_cnt_q     <= load_cnt_d;
            // Only the shadow bank (the one not selected) is ever written.
            for (int unsigned i = 0; i < NN; i++) begin
                if (wr_fire && (load_cnt_q == CW'(i))) begin
                    if (bank_sel_q) begin
                        bank0_q[i] <= wr.wr_data;
                    end else begin
                        bank1_q[i] <= wr.wr_data;
                    end
                end
            end
        end
    end

    assign wr.wr_ready   = (state_q == StLoad);
    assign shadow_full   = (state_q == StFull);
    assign active_valid  = active_valid_q;
    assign load_cnt      = load_cnt_q;
    assign fix_b         = bank_sel_q ? bank1_q : bank0_q;
endmodule

// File: tb/tb_weight_cache_pingpong.sv
// Self-checking bench for weight_cache_pingpong: directed scenarios plus random traffic,
// compared every cycle against an array-based reference model.
module tb_weight_cache_pingpong;
    localparam int N  = 3;
    localparam int DW = 8;
    localparam int NN = N * N;
    localparam int CW = $clog2(NN + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              load_clr;
    logic              swap_req;
    logic              hold;
    logic [NN*DW-1:0]  fix_b;
    logic              shadow_full;
    logic              active_valid;
    logic [CW-1:0]     load_cnt;

    weight_cache_pingpong_if #(.DW(DW)) wr_if ();

    weight_cache_pingpong #(.N(N), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr_if),
        .load_clr     (load_clr),
        .swap_req     (swap_req),
        .hold         (hold),
        .fix_b        (fix_b),
        .shadow_full  (shadow_full),
        .active_valid (active_valid),
        .load_cnt     (load_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: shadow contents, number loaded, active contents.
    logic [DW-1:0] m_shadow [NN];
    logic [DW-1:0] m_active [NN];
    int            m_cnt;
    bit            m_av;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [NN*DW-1:0] obs,
                         input logic [NN*DW-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit clr, input bit sw,
                        input bit hd, input bit r);
        logic [NN*DW-1:0] exp_fix;
        logic [DW-1:0]    tmp;
        bit               full;
        bit               do_swap;
        wr_if.wr_valid = v;
        wr_if.wr_data  = d;
        load_clr       = clr;
        swap_req       = sw;
        hold           = hd;
        rst            = r;
        @(posedge clk);
        full = (m_cnt == NN);
`ifdef WCACHE_AUTO_SWAP_EN
        do_swap = full && !hd;
`else
        do_swap = full && sw && !hd;
`endif
        if (r) begin
            for (int i = 0; i < NN; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
            m_cnt = 0;
            m_av  = 1'b0;
        end else if (clr) begin
            m_cnt = 0;
        end else if (do_swap) begin
            for (int i = 0; i < NN; i++) begin
                tmp         = m_active[i];
                m_active[i] = m_shadow[i];
                m_shadow[i] = tmp;
            end
            m_cnt = 0;
            m_av  = 1'b1;
        end else if (v && !full) begin
            m_shadow[m_cnt] = d;
            m_cnt++;
        end
        #1;
        for (int i = 0; i < NN; i++) exp_fix[i*DW +: DW] = m_active[i];
        check("fix_b", fix_b, exp_fix);
        check("wr_ready", {{(NN*DW-1){1'b0}}, wr_if.wr_ready}, (m_cnt < NN) ? 1 : 0);
        check("shadow_full", {{(NN*DW-1){1'b0}}, shadow_full}, (m_cnt == NN) ? 1 : 0);
        check("active_valid", {{(NN*DW-1){1'b0}}, active_valid}, {{(NN*DW-1){1'b0}}, m_av});
        check("load_cnt", {{(NN*DW-CW){1'b0}}, load_cnt}, (NN*DW)'(m_cnt));
    endtask

    task automatic load_rand(input int n, input bit sw);
        for (int i = 0; i < n; i++) step(1'b1, 8'($urandom), 1'b0, sw, 1'b0, 1'b0);
    endtask

    initial begin
        m_cnt = 0;
        m_av  = 1'b0;
        for (int i = 0; i < NN; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        step(1'b1, 8'hff, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Stream 1..9, offer one extra write while full, then swap.
        for (int i = 1; i <= NN; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'haa, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Stream 10..18 with swap_req held and the array busy.
        for (int i = 10; i <= 18; i++) step(1'b1, 8'(i), 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Partial load discarded by load_clr together with a 5th write.
        load_rand(4, 1'b0);
        step(1'b1, 8'h5a, 1'b1, 1'b0, 1'b0, 1'b0);
        load_rand(NN, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // swap_req high throughout LOAD; swap lands the edge after FULL.
        load_rand(NN, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset while FULL.
        load_rand(NN, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 8'($urandom), ($urandom % 20) == 0,
                 ($urandom % 2) == 1, ($urandom % 3) == 0, ($urandom % 80) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
